execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 182 ++++++++++++++++++
 tb/tb_execute_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32 execute stage: operand muxing, ALU, branch resolution, EX/MEM register
// Optional operand forwarding from MEM/WB is enabled by defining FORWARDING_EN.
module execute_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] immediateValue,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic        pcUpdate,
    input  logic        memoryReadEnable,
    input  logic        memoryWriteEnable,
    input  logic        registerWriteEnable,
    input  logic        pcAdderSrc,
    input  logic        writeBackFromMemoryOrAlu,
    input  logic [1:0]  aluSrc1,
    input  logic [1:0]  aluSrc2,
    input  logic [2:0]  aluOperation,
    input  logic [4:0]  memRd,
    input  logic        memRegisterWriteEnable,
    input  logic [31:0] memAluResult,
    input  logic [4:0]  wbRd,
    input  logic        wbRegisterWriteEnable,
    input  logic [31:0] wbWriteData,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] aluResultOut,
    output logic [31:0] storeDataOut,
    output logic [4:0]  rdOut,
    output logic [2:0]  func3Out,
    output logic        memoryReadEnableOut,
    output logic        memoryWriteEnableOut,
    output logic        registerWriteEnableOut,
    output logic        writeBackFromMemoryOrAluOut,
    output logic        branchTaken,
    output logic [31:0] branchTarget
);

    localparam logic [2:0] OP_FUNC = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [31:0] jalr_sum;
    logic        branch_cond;
    logic        unused_func7;

    // Only func7[5] distinguishes SUB/SRA; the remaining bits are don't-care here.
    assign unused_func7 = ^{func7[6], func7[4:0]};

`ifdef FORWARDING_EN
    // MEM result is younger than WB data, so it wins when both match.
    always_comb begin
        rs1_data = readData1;
        if (memRegisterWriteEnable && (memRd != 5'd0) && (memRd == rs1))
            rs1_data = memAluResult;
        else if (wbRegisterWriteEnable && (wbRd != 5'd0) && (wbRd == rs1))
            rs1_data = wbWriteData;
    end

    always_comb begin
        rs2_data = readData2;
        if (memRegisterWriteEnable && (memRd != 5'd0) && (memRd == rs2))
            rs2_data = memAluResult;
        else if (wbRegisterWriteEnable && (wbRd != 5'd0) && (wbRd == rs2))
            rs2_data = wbWriteData;
    end
`else
    logic unused_fwd;

    assign rs1_data   = readData1;
    assign rs2_data   = readData2;
    assign unused_fwd = ^{rs1, rs2, memRd, memRegisterWriteEnable, memAluResult,
                          wbRd, wbRegisterWriteEnable, wbWriteData};
`endif

    always_comb begin
        case (aluSrc1)
            2'b00:   op_a = rs1_data;
            2'b01:   op_a = pc;
            default: op_a = 32'd0;
        endcase
    end

    always_comb begin
        case (aluSrc2)
            2'b00:   op_b = rs2_data;
            2'b01:   op_b = immediateValue;
            2'b10:   op_b = 32'd4;
            default: op_b = 32'd0;
        endcase
    end

    always_comb begin
        alu_result = 32'd0;
        case (aluOperation)
            OP_ADD: alu_result = op_a + op_b;
            OP_SUB: alu_result = op_a - op_b;
            OP_FUNC: begin
                case (func3)
                    3'b000: begin
                        // Immediate forms never subtract, even if imm bits alias func7[5].
                        if (func7[5] && (aluSrc2 == 2'b00))
                            alu_result = op_a - op_b;
                        else
                            alu_result = op_a + op_b;
                    end
                    3'b001: alu_result = op_a << op_b[4:0];
                    3'b010: alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
                    3'b011: alu_result = (op_a < op_b) ? 32'd1 : 32'd0;
                    3'b100: alu_result = op_a ^ op_b;
                    3'b101: begin
                        if (func7[5])
                            alu_result = $signed(op_a) >>> op_b[4:0];
                        else
                            alu_result = op_a >> op_b[4:0];
                    end
                    3'b110: alu_result = op_a | op_b;
                    default: alu_result = op_a & op_b;
                endcase
            end
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (func3)
            3'b000: branch_cond = (rs1_data == rs2_data);
            3'b001: branch_cond = (rs1_data != rs2_data);
            3'b100: branch_cond = ($signed(rs1_data) < $signed(rs2_data));
            3'b101: branch_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110: branch_cond = (rs1_data < rs2_data);
            3'b111: branch_cond = (rs1_data >= rs2_data);
            default: branch_cond = 1'b0;
        endcase
    end

    assign jalr_sum     = rs1_data + immediateValue;
    assign branchTarget = pcAdderSrc ? {jalr_sum[31:1], 1'b0} : (pc + immediateValue);
    // Jumps use any non-SUB op; conditional branches are tagged with SUB.
    assign branchTaken  = !stall && pcUpdate &&
                          ((aluOperation != OP_SUB) || branch_cond);

    always_ff @(posedge clock) begin
        if (!reset) begin
            aluResultOut                <= 32'd0;
            storeDataOut                <= 32'd0;
            rdOut                       <= 5'd0;
            func3Out                    <= 3'd0;
            memoryReadEnableOut         <= 1'b0;
            memoryWriteEnableOut        <= 1'b0;
            registerWriteEnableOut      <= 1'b0;
            writeBackFromMemoryOrAluOut <= 1'b0;
        end else if (flush) begin
            // Bubble: kill every side effect, leave datapath values as they were.
            rdOut                  <= 5'd0;
            memoryReadEnableOut    <= 1'b0;
            memoryWriteEnableOut   <= 1'b0;
            registerWriteEnableOut <= 1'b0;
        end else if (!stall) begin
            aluResultOut                <= alu_result;
            storeDataOut                <= rs2_data;
            rdOut                       <= rd;
            func3Out                    <= func3;
            memoryReadEnableOut         <= memoryReadEnable;
            memoryWriteEnableOut        <= memoryWriteEnable;
            registerWriteEnableOut      <= registerWriteEnable;
            writeBackFromMemoryOrAluOut <= writeBackFromMemoryOrAlu;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against a behavioural model
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc, readData1, readData2, immediateValue;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        pcUpdate, memoryReadEnable, memoryWriteEnable, registerWriteEnable;
    logic        pcAdderSrc, writeBackFromMemoryOrAlu;
    logic [1:0]  aluSrc1, aluSrc2;
    logic [2:0]  aluOperation;
    logic [4:0]  memRd, wbRd;
    logic        memRegisterWriteEnable, wbRegisterWriteEnable;
    logic [31:0] memAluResult, wbWriteData;
    logic        stall, flush;
    logic [31:0] aluResultOut, storeDataOut;
    logic [4:0]  rdOut;
    logic [2:0]  func3Out;
    logic        memoryReadEnableOut, memoryWriteEnableOut, registerWriteEnableOut;
    logic        writeBackFromMemoryOrAluOut;
    logic        branchTaken;
    logic [31:0] branchTarget;

    int checks = 0;
    int passed = 0;

    execute_stage dut (
        .clock(clock), .reset(reset), .pc(pc), .readData1(readData1), .readData2(readData2),
        .immediateValue(immediateValue), .rs1(rs1), .rs2(rs2), .rd(rd), .func3(func3),
        .func7(func7), .pcUpdate(pcUpdate), .memoryReadEnable(memoryReadEnable),
        .memoryWriteEnable(memoryWriteEnable), .registerWriteEnable(registerWriteEnable),
        .pcAdderSrc(pcAdderSrc), .writeBackFromMemoryOrAlu(writeBackFromMemoryOrAlu),
        .aluSrc1(aluSrc1), .aluSrc2(aluSrc2), .aluOperation(aluOperation),
        .memRd(memRd), .memRegisterWriteEnable(memRegisterWriteEnable),
        .memAluResult(memAluResult), .wbRd(wbRd), .wbRegisterWriteEnable(wbRegisterWriteEnable),
        .wbWriteData(wbWriteData), .stall(stall), .flush(flush),
        .aluResultOut(aluResultOut), .storeDataOut(storeDataOut), .rdOut(rdOut),
        .func3Out(func3Out), .memoryReadEnableOut(memoryReadEnableOut),
        .memoryWriteEnableOut(memoryWriteEnableOut),
        .registerWriteEnableOut(registerWriteEnableOut),
        .writeBackFromMemoryOrAluOut(writeBackFromMemoryOrAluOut),
        .branchTaken(branchTaken), .branchTarget(branchTarget)
    );

    always #5 clock = ~clock;

    // Architectural value of a source register as the instruction should see it.
    function automatic logic [31:0] ref_src(input logic [4:0] r, input logic [31:0] file_val);
`ifdef FORWARDING_EN
        if (memRegisterWriteEnable && memRd != 0 && memRd == r) return memAluResult;
        if (wbRegisterWriteEnable && wbRd != 0 && wbRd == r) return wbWriteData;
`endif
        return file_val;
    endfunction

    function automatic logic [31:0] ref_result();
        logic [31:0] a, b;
        a = (aluSrc1 == 0) ? ref_src(rs1, readData1) : (aluSrc1 == 1) ? pc : 32'd0;
        b = (aluSrc2 == 0) ? ref_src(rs2, readData2) : (aluSrc2 == 1) ? immediateValue :
            (aluSrc2 == 2) ? 32'd4 : 32'd0;
        if (aluOperation == 1) return a + b;
        if (aluOperation == 2) return a - b;
        if (aluOperation != 0) return 32'd0;
        case (func3)
            0: return (func7[5] && aluSrc2 == 0) ? a - b : a + b;
            1: return a << (b % 32);
            2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return func7[5] ? 32'(int'(a) >>> (b % 32)) : a >> (b % 32);
            6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_taken();
        int unsigned x, y;
        bit c;
        x = ref_src(rs1, readData1);
        y = ref_src(rs2, readData2);
        case (func3)
            0: c = (x == y);
            1: c = (x != y);
            4: c = (int'(x) < int'(y));
            5: c = (int'(x) >= int'(y));
            6: c = (x < y);
            7: c = (x >= y);
            default: c = 0;
        endcase
        return !stall && pcUpdate && (aluOperation != 2 || c);
    endfunction

    function automatic logic [31:0] ref_target();
        if (pcAdderSrc) return (ref_src(rs1, readData1) + immediateValue) & ~32'd1;
        return pc + immediateValue;
    endfunction

    task automatic clear_inputs();
        pc = 0; readData1 = 0; readData2 = 0; immediateValue = 0;
        rs1 = 0; rs2 = 0; rd = 0; func3 = 0; func7 = 0;
        pcUpdate = 0; memoryReadEnable = 0; memoryWriteEnable = 0; registerWriteEnable = 0;
        pcAdderSrc = 0; writeBackFromMemoryOrAlu = 0; aluSrc1 = 0; aluSrc2 = 0; aluOperation = 0;
        memRd = 0; memRegisterWriteEnable = 0; memAluResult = 0;
        wbRd = 0; wbRegisterWriteEnable = 0; wbWriteData = 0; stall = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        readData1 = 32'hDEAD; readData2 = 32'hBEEF; rd = 9; aluOperation = 1;
        memoryWriteEnable = 1; registerWriteEnable = 1; memoryReadEnable = 1;
        writeBackFromMemoryOrAlu = 1; func3 = 3;
        reset = 0;
        tick(); tick();
        checks++;
        if ({aluResultOut, storeDataOut, rdOut, func3Out, memoryReadEnableOut, memoryWriteEnableOut,
             registerWriteEnableOut, writeBackFromMemoryOrAluOut} !== 76'd0)
            $display("FAIL reset_state: got alu=%h st=%h rd=%0d f3=%0d en=%b%b%b%b, want all 0",
                     aluResultOut, storeDataOut, rdOut, func3Out, memoryReadEnableOut,
                     memoryWriteEnableOut, registerWriteEnableOut, writeBackFromMemoryOrAluOut);
        else passed++;
        reset = 1;
    endtask

    task automatic test_sub();
        clear_inputs();
        func7 = 7'b0100000; readData1 = 10; readData2 = 3;
        tick();
        checks++;
        if (aluResultOut !== 32'd7) $display("FAIL sub_10_3: got %0d want 7", aluResultOut);
        else passed++;
    endtask

    task automatic test_forwarding();
        logic [31:0] want;
        clear_inputs();
        rs1 = 5; readData1 = 32'h11; memRd = 5; memRegisterWriteEnable = 1; memAluResult = 32'h55;
        wbRd = 5; wbRegisterWriteEnable = 1; wbWriteData = 32'h99; aluOperation = 1; aluSrc2 = 3;
`ifdef FORWARDING_EN
        want = 32'h55;
`else
        want = 32'h11;
`endif
        tick();
        checks++;
        if (aluResultOut !== want) $display("FAIL fwd_priority: got %h want %h", aluResultOut, want);
        else passed++;
    endtask

    task automatic test_branch();
        clear_inputs();
        pcUpdate = 1; aluOperation = 2; func3 = 1; readData1 = 4; readData2 = 4;
        pc = 32'h100; immediateValue = 32'h20;
        #1;
        checks++;
        if (branchTaken !== 1'b0) $display("FAIL bne_equal: got %b want 0", branchTaken);
        else passed++;
        readData2 = 5;
        #1;
        checks++;
        if (branchTaken !== 1'b1) $display("FAIL bne_taken: got %b want 1", branchTaken);
        else passed++;
        checks++;
        if (branchTarget !== 32'h120) $display("FAIL bne_target: got %h want 120", branchTarget);
        else passed++;
        clear_inputs();
        pcAdderSrc = 1; pcUpdate = 1; aluOperation = 1; readData1 = 32'h203; immediateValue = 4;
        #1;
        checks++;
        if (branchTaken !== 1'b1) $display("FAIL jalr_taken: got %b want 1", branchTaken);
        else passed++;
        checks++;
        if (branchTarget !== 32'h206) $display("FAIL jalr_target: got %h want 206", branchTarget);
        else passed++;
        stall = 1;
        #1;
        checks++;
        if (branchTaken !== 1'b0) $display("FAIL stall_kills_branch: got %b want 0", branchTaken);
        else passed++;
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        readData1 = 32'h1000; immediateValue = 32'h8; aluSrc2 = 1; aluOperation = 1;
        readData2 = 32'hCAFE; rd = 12; func3 = 2; memoryWriteEnable = 1; registerWriteEnable = 1;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            readData1 = $urandom; readData2 = $urandom; rd = 5'($urandom);
            func3 = 3'($urandom); memoryWriteEnable = 0; memoryReadEnable = 1;
            tick();
            checks++;
            if (aluResultOut !== 32'h1008 || storeDataOut !== 32'hCAFE || rdOut !== 5'd12 ||
                func3Out !== 3'd2 || memoryWriteEnableOut !== 1'b1 || memoryReadEnableOut !== 1'b0 ||
                registerWriteEnableOut !== 1'b1)
                $display("FAIL stall_hold_%0d: got alu=%h st=%h rd=%0d f3=%0d mw=%b mr=%b rw=%b, want 1008 cafe 12 2 1 0 1",
                         i, aluResultOut, storeDataOut, rdOut, func3Out, memoryWriteEnableOut,
                         memoryReadEnableOut, registerWriteEnableOut);
            else passed++;
        end
        flush = 1;
        tick();
        checks++;
        if ({memoryReadEnableOut, memoryWriteEnableOut, registerWriteEnableOut, rdOut} !== 8'd0)
            $display("FAIL flush_over_stall: got mr=%b mw=%b rw=%b rd=%0d, want 0",
                     memoryReadEnableOut, memoryWriteEnableOut, registerWriteEnableOut, rdOut);
        else passed++;
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        readData1 = 32'h77; aluOperation = 1; rd = 3; registerWriteEnable = 1; readData2 = 32'h5;
        tick();
        stall = 1;
        tick();
        reset = 0;
        tick();
        checks++;
        if ({aluResultOut, storeDataOut, rdOut, registerWriteEnableOut} !== 70'd0)
            $display("FAIL reset_in_stall: got alu=%h st=%h rd=%0d rw=%b, want 0",
                     aluResultOut, storeDataOut, rdOut, registerWriteEnableOut);
        else passed++;
        reset = 1; stall = 0;
        readData1 = 32'h40; readData2 = 32'h2; rd = 17; registerWriteEnable = 1;
        tick();
        checks++;
        if (aluResultOut !== 32'h42 || rdOut !== 5'd17 || registerWriteEnableOut !== 1'b1)
            $display("FAIL capture_after_reset: got alu=%h rd=%0d rw=%b, want 42 17 1",
                     aluResultOut, rdOut, registerWriteEnableOut);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] w_res, w_st, w_tgt;
        logic        w_tk;
        for (int i = 0; i < 60; i++) begin
            clear_inputs();
            pc = $urandom; immediateValue = $urandom;
            readData1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom_range(0, 9) : $urandom;
            readData2 = ($urandom_range(0, 3) == 0) ? readData1 : $urandom;
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom);
            func3 = 3'($urandom); func7 = $urandom_range(0, 1) ? 7'b0100000 : 7'b0000000;
            aluOperation = 3'($urandom_range(0, 4)); aluSrc1 = 2'($urandom); aluSrc2 = 2'($urandom);
            pcUpdate = 1'($urandom); pcAdderSrc = 1'($urandom);
            memoryReadEnable = 1'($urandom); memoryWriteEnable = 1'($urandom);
            registerWriteEnable = 1'($urandom); writeBackFromMemoryOrAlu = 1'($urandom);
            memRd = 5'($urandom_range(0, 3)); memRegisterWriteEnable = 1'($urandom);
            memAluResult = $urandom;
            wbRd = 5'($urandom_range(0, 3)); wbRegisterWriteEnable = 1'($urandom);
            wbWriteData = $urandom;
            w_res = ref_result(); w_st = ref_src(rs2, readData2);
            w_tk = ref_taken(); w_tgt = ref_target();
            #1;
            checks++;
            if (branchTaken !== w_tk || branchTarget !== w_tgt)
                $display("FAIL rand_branch_%0d: got tk=%b tgt=%h want tk=%b tgt=%h",
                         i, branchTaken, branchTarget, w_tk, w_tgt);
            else passed++;
            tick();
            checks++;
            if (aluResultOut !== w_res || storeDataOut !== w_st || rdOut !== rd ||
                func3Out !== func3 || memoryReadEnableOut !== memoryReadEnable ||
                memoryWriteEnableOut !== memoryWriteEnable ||
                registerWriteEnableOut !== registerWriteEnable ||
                writeBackFromMemoryOrAluOut !== writeBackFromMemoryOrAlu)
                $display("FAIL rand_reg_%0d: op=%0d f3=%0d got alu=%h st=%h rd=%0d want alu=%h st=%h rd=%0d",
                         i, aluOperation, func3, aluResultOut, storeDataOut, rdOut, w_res, w_st, rd);
            else passed++;
        end
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        test_reset();
        test_sub();
        test_forwarding();
        test_branch();
        test_stall_flush();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
